// File: rtl/bp_be_branch_resolver.sv
// ---------------------------------------------------------------------------
// bp_be_branch_resolver
//
// Backend branch resolver. Tracks the architecturally expected next PC from
// resolved instruction packets and checks it against the PC of every issued
// instruction. On a mismatch the wrong-path instruction is poisoned, a
// redirect is offered to the front end over valid/ready, and further issues
// are poisoned until the redirect target itself is issued.
//
// Optional feature macro: BP_BE_BRANCH_STATS_EN
//   defined   : saturating control-flow and mispredict counters
//   undefined : counter outputs tied to zero, no counter flops
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   flush_i                   exception/trap flush, aborts resolver state
//   br_v_i, br_branch_i,
//   br_btaken_i, br_npc_i     resolved instruction packet
//   issue_v_i, issue_pc_i     instruction issued this cycle
//   poison_o                  kill the instruction being issued this cycle
//   redirect_v_o/ready_i      redirect handshake to the FE command queue
//   redirect_npc_o,
//   redirect_branch_o,
//   redirect_btaken_o         redirect target and attributes
//   busy_o                    resolver not in the run state
//   mispredict_cnt_o,
//   branch_cnt_o              statistics counters (optional)
//
// Parameters
//   vaddr_width_p             virtual address width of the processor config
//   ctr_width_p               width of the statistics counters
// ---------------------------------------------------------------------------
module bp_be_branch_resolver
  #(parameter int vaddr_width_p = 39
  , parameter int ctr_width_p   = 32
  )
  (input  logic                     clk_i
  , input  logic                     reset_i
  , input  logic                     flush_i
  , input  logic                     br_v_i
  , input  logic                     br_branch_i
  , input  logic                     br_btaken_i
  , input  logic [vaddr_width_p-1:0] br_npc_i
  , input  logic                     issue_v_i
  , input  logic [vaddr_width_p-1:0] issue_pc_i
  , output logic                     poison_o
  , output logic                     redirect_v_o
  , input  logic                     redirect_ready_i
  , output logic [vaddr_width_p-1:0] redirect_npc_o
  , output logic                     redirect_branch_o
  , output logic                     redirect_btaken_o
  , output logic                     busy_o
  , output logic [ctr_width_p-1:0]   mispredict_cnt_o
  , output logic [ctr_width_p-1:0]   branch_cnt_o
  );

  typedef enum logic [1:0] {
    e_run      = 2'd0,
    e_redirect = 2'd1,
    e_drain    = 2'd2
  } state_e;

  state_e                   state_q;
  logic [vaddr_width_p-1:0] npc_q;
  logic                     npc_v_q;
  logic [vaddr_width_p-1:0] tgt_q;
  logic                     branch_q;
  logic                     btaken_q;
  logic                     last_branch_q;
  logic                     last_btaken_q;
  logic                     reset_q;

  logic                     quiet;
  logic                     exp_v;
  logic [vaddr_width_p-1:0] exp_npc;
  logic                     mispredict;
  logic                     drain_hit;
  logic                     redirect_v;
  logic                     handshake;

  // Outputs are held at zero during reset and for one cycle after it, so
  // no comparison is made in that window either.
  assign quiet   = reset_i | reset_q;

  // A packet in the same cycle as an issue is the one that issue is checked
  // against, so the incoming packet bypasses the stored expectation.
  assign exp_v   = br_v_i | npc_v_q;
  assign exp_npc = br_v_i ? br_npc_i : npc_q;

  assign mispredict = ~quiet & ~flush_i & (state_q == e_run)
                    & issue_v_i & exp_v & (issue_pc_i != exp_npc);
  assign drain_hit  = (state_q == e_drain) & issue_v_i & (issue_pc_i == tgt_q);

  // Flush kills a pending redirect in the same cycle so no handshake occurs.
  assign redirect_v = ~quiet & ~flush_i & (state_q == e_redirect);
  assign handshake  = redirect_v & redirect_ready_i;

  always_comb begin
    poison_o = 1'b0;
    if (quiet) begin
      poison_o = 1'b0;
    end else if (flush_i) begin
      poison_o = issue_v_i;
    end else begin
      case (state_q)
        e_run:      poison_o = mispredict;
        e_redirect: poison_o = issue_v_i;
        e_drain:    poison_o = issue_v_i & ~drain_hit;
        default:    poison_o = 1'b0;
      endcase
    end
  end

  assign redirect_v_o      = redirect_v;
  assign redirect_npc_o    = quiet ? '0 : tgt_q;
  assign redirect_branch_o = ~quiet & branch_q;
  assign redirect_btaken_o = ~quiet & btaken_q;
  assign busy_o            = ~quiet & (state_q != e_run);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_run;
      npc_q         <= '0;
      npc_v_q       <= 1'b0;
      tgt_q         <= '0;
      branch_q      <= 1'b0;
      btaken_q      <= 1'b0;
      last_branch_q <= 1'b0;
      last_btaken_q <= 1'b0;
      reset_q       <= 1'b1;
    end else begin
      reset_q <= 1'b0;

      // Every resolved packet refreshes the expectation, whatever the state.
      if (br_v_i) begin
        npc_q         <= br_npc_i;
        npc_v_q       <= 1'b1;
        last_branch_q <= br_branch_i;
        last_btaken_q <= br_btaken_i;
      end

      if (flush_i) begin
        state_q <= e_run;
        npc_v_q <= 1'b0;
      end else begin
        case (state_q)
          e_run: begin
            if (mispredict) begin
              state_q  <= e_redirect;
              tgt_q    <= exp_npc;
              branch_q <= br_v_i ? br_branch_i : last_branch_q;
              btaken_q <= br_v_i ? br_btaken_i : last_btaken_q;
            end
          end
          e_redirect: begin
            if (handshake) state_q <= e_drain;
          end
          e_drain: begin
            if (drain_hit) state_q <= e_run;
          end
          default: state_q <= e_run;
        endcase
      end
    end
  end

`ifdef BP_BE_BRANCH_STATS_EN
  localparam logic [ctr_width_p-1:0] ctr_one = ctr_width_p'(1);

  logic [ctr_width_p-1:0] branch_cnt_q;
  logic [ctr_width_p-1:0] mispredict_cnt_q;

  // Counters saturate at all-ones and survive flushes; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (br_v_i & br_branch_i & ~(&branch_cnt_q))
        branch_cnt_q <= branch_cnt_q + ctr_one;
      if (mispredict & ~(&mispredict_cnt_q))
        mispredict_cnt_q <= mispredict_cnt_q + ctr_one;
    end
  end

  assign branch_cnt_o     = quiet ? '0 : branch_cnt_q;
  assign mispredict_cnt_o = quiet ? '0 : mispredict_cnt_q;
`else
  assign branch_cnt_o     = '0;
  assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_branch_resolver.sv
module tb_bp_be_branch_resolver;
  localparam int VW = 39;
`ifdef BP_BE_BRANCH_STATS_EN
  localparam int CW = 4;
  localparam bit STATS = 1'b1;
`else
  localparam int CW = 32;
  localparam bit STATS = 1'b0;
`endif
  localparam longint MAXC = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, fl = 1'b0, brv = 1'b0, brb = 1'b0, brt = 1'b0;
  logic [VW-1:0] bnpc = '0, ipc = '0;
  logic          iv = 1'b0, rdy = 1'b0;
  logic          poison, rv, rb, rt, busy;
  logic [VW-1:0] rnpc;
  logic [CW-1:0] mcnt, bcnt;

  bp_be_branch_resolver #(.vaddr_width_p(VW), .ctr_width_p(CW)) dut (
    .clk_i(clk), .reset_i(rst), .flush_i(fl),
    .br_v_i(brv), .br_branch_i(brb), .br_btaken_i(brt), .br_npc_i(bnpc),
    .issue_v_i(iv), .issue_pc_i(ipc),
    .poison_o(poison), .redirect_v_o(rv), .redirect_ready_i(rdy),
    .redirect_npc_o(rnpc), .redirect_branch_o(rb), .redirect_btaken_o(rt),
    .busy_o(busy), .mispredict_cnt_o(mcnt), .branch_cnt_o(bcnt));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the resolver is waiting for, described as flags.
  bit            m_rst_prev, m_have_npc, m_last_b, m_last_t;
  bit            m_pending, m_draining, m_rb, m_rt;
  logic [VW-1:0] m_npc, m_tgt;
  longint        m_bcnt, m_mcnt;
  bit            m_mis, m_hs, m_hit;

  // Expected and observed outputs for the current cycle.
  bit            e_poison, e_rv, e_rb, e_rt, e_busy;
  logic [VW-1:0] e_rnpc;
  logic [CW-1:0] e_bcnt, e_mcnt;
  logic          o_poison, o_rv, o_rb, o_rt, o_busy;
  logic [VW-1:0] o_rnpc;
  logic [CW-1:0] o_bcnt, o_mcnt;

  task automatic model_eval();
    bit            quiet;
    bit            xv;
    logic [VW-1:0] xn;
    quiet = rst | m_rst_prev;
    xv    = brv | m_have_npc;
    xn    = brv ? bnpc : m_npc;
    e_poison = 0; e_rv = 0; e_busy = 0;
    m_mis = 0; m_hs = 0; m_hit = 0;
    e_rnpc = quiet ? '0 : m_tgt;
    e_rb   = !quiet && m_rb;
    e_rt   = !quiet && m_rt;
    e_bcnt = (STATS && !quiet) ? m_bcnt[CW-1:0] : '0;
    e_mcnt = (STATS && !quiet) ? m_mcnt[CW-1:0] : '0;
    if (!quiet) begin
      e_busy = m_pending | m_draining;
      if (fl) begin
        e_poison = iv;
      end else if (m_pending) begin
        e_poison = iv; e_rv = 1; m_hs = rdy;
      end else if (m_draining) begin
        m_hit = iv && (ipc == m_tgt);
        e_poison = iv && !m_hit;
      end else begin
        m_mis = iv && xv && (ipc != xn);
        e_poison = m_mis;
      end
    end
  endtask

  task automatic model_commit();
    bit            ob, ot;
    logic [VW-1:0] xn;
    ob = m_last_b; ot = m_last_t;
    xn = brv ? bnpc : m_npc;
    if (rst) begin
      m_rst_prev = 1; m_have_npc = 0; m_npc = '0; m_last_b = 0; m_last_t = 0;
      m_pending = 0; m_draining = 0; m_tgt = '0; m_rb = 0; m_rt = 0;
      m_bcnt = 0; m_mcnt = 0;
    end else begin
      m_rst_prev = 0;
      if (brv) begin
        m_npc = bnpc; m_have_npc = 1; m_last_b = brb; m_last_t = brt;
        if (brb && m_bcnt < MAXC) m_bcnt++;
      end
      if (fl) begin
        m_pending = 0; m_draining = 0; m_have_npc = 0;
      end else if (m_mis) begin
        m_pending = 1; m_tgt = xn;
        m_rb = brv ? brb : ob;
        m_rt = brv ? brt : ot;
        if (m_mcnt < MAXC) m_mcnt++;
      end else if (m_hs) begin
        m_pending = 0; m_draining = 1;
      end else if (m_hit) begin
        m_draining = 0;
      end
    end
  endtask

  // One clock cycle: drive, predict, sample away from the edge, then clock.
  task automatic cyc(input bit r, input bit f, input bit bv, input bit bb, input bit bt,
                     input logic [VW-1:0] bn, input bit v, input logic [VW-1:0] pc,
                     input bit rd);
    @(negedge clk);
    rst = r; fl = f; brv = bv; brb = bb; brt = bt; bnpc = bn; iv = v; ipc = pc; rdy = rd;
    #1;
    model_eval();
    o_poison = poison; o_rv = rv; o_rb = rb; o_rt = rt; o_busy = busy;
    o_rnpc = rnpc; o_bcnt = bcnt; o_mcnt = mcnt;
    @(posedge clk);
    model_commit();
  endtask

  task automatic idle(input bit rd);
    cyc(0, 0, 0, 0, 0, '0, 0, '0, rd);
  endtask

  task automatic test_reset();
    cyc(1, 0, 1, 1, 1, VW'('h44), 1, VW'('h88), 1);
    $display("reset cycle: poison=%0b rv=%0b busy=%0b npc=%0h", o_poison, o_rv, o_busy, o_rnpc);
    n_checks++; if (o_poison !== 1'b0) $display("FAIL rst_poison got=%0b want=0", o_poison); else n_pass++;
    n_checks++; if (o_rv !== 1'b0) $display("FAIL rst_redirect_v got=%0b want=0", o_rv); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy got=%0b want=0", o_busy); else n_pass++;
    n_checks++; if (o_rnpc !== '0) $display("FAIL rst_npc got=%0h want=0", o_rnpc); else n_pass++;
    // Cycle after reset: would mismatch, but outputs must stay zero.
    cyc(0, 0, 1, 1, 1, VW'('h10), 1, VW'('h20), 0);
    $display("post-reset cycle: poison=%0b busy=%0b", o_poison, o_busy);
    n_checks++; if (o_poison !== 1'b0) $display("FAIL postrst_poison got=%0b want=0", o_poison); else n_pass++;
    idle(0);
    n_checks++; if (o_busy !== 1'b0 || o_rv !== 1'b0)
      $display("FAIL postrst_state busy=%0b rv=%0b want=0/0", o_busy, o_rv); else n_pass++;
  endtask

  task automatic test_no_packet();
    cyc(1, 0, 0, 0, 0, '0, 0, '0, 0);
    idle(0);
    cyc(0, 0, 0, 0, 0, '0, 1, VW'('h8000_0000), 0);
    $display("issue 80000000 no packet: poison=%0b busy=%0b", o_poison, o_busy);
    n_checks++; if (o_poison !== 1'b0) $display("FAIL nopkt_poison got=%0b want=0", o_poison); else n_pass++;
    idle(0);
    n_checks++; if (o_busy !== 1'b0) $display("FAIL nopkt_busy got=%0b want=0", o_busy); else n_pass++;
  endtask

  task automatic test_correct_predict();
    cyc(0, 0, 1, 0, 0, VW'('h1004), 0, '0, 0);
    cyc(0, 0, 0, 0, 0, '0, 1, VW'('h1004), 0);
    $display("issue 1004 after npc 1004: poison=%0b", o_poison);
    n_checks++; if (o_poison !== 1'b0) $display("FAIL correct_poison got=%0b want=0", o_poison); else n_pass++;
    idle(1);
    n_checks++; if (o_rv !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL correct_state rv=%0b busy=%0b want=0/0", o_rv, o_busy); else n_pass++;
  endtask

  task automatic test_mispredict_redirect();
    cyc(0, 0, 1, 1, 1, VW'('h2000), 1, VW'('h1008), 0);
    $display("packet 2000 with issue 1008: poison=%0b", o_poison);
    n_checks++; if (o_poison !== 1'b1) $display("FAIL mis_poison got=%0b want=1", o_poison); else n_pass++;
    idle(0);
    $display("redirect: v=%0b npc=%0h br=%0b tk=%0b", o_rv, o_rnpc, o_rb, o_rt);
    n_checks++; if (o_rv !== 1'b1) $display("FAIL mis_redirect_v got=%0b want=1", o_rv); else n_pass++;
    n_checks++; if (o_rnpc !== VW'('h2000)) $display("FAIL mis_redirect_npc got=%0h want=2000", o_rnpc); else n_pass++;
    n_checks++; if (o_rb !== 1'b1 || o_rt !== 1'b1)
      $display("FAIL mis_attr got=%0b%0b want=11", o_rb, o_rt); else n_pass++;
  endtask

  task automatic test_stall_drain();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, '0, 1, (i % 2 == 0) ? VW'('h100C) : VW'('h1010), 0);
      $display("stall %0d: poison=%0b rv=%0b npc=%0h", i, o_poison, o_rv, o_rnpc);
      n_checks++; if (o_poison !== 1'b1 || o_rv !== 1'b1 || o_rnpc !== VW'('h2000) || o_rb !== 1'b1)
        $display("FAIL stall_hold poison=%0b rv=%0b npc=%0h br=%0b want=1/1/2000/1",
                 o_poison, o_rv, o_rnpc, o_rb); else n_pass++;
    end
    idle(1);
    n_checks++; if (o_rv !== 1'b1) $display("FAIL hs_valid got=%0b want=1", o_rv); else n_pass++;
    cyc(0, 0, 0, 0, 0, '0, 1, VW'('h100C), 0);
    $display("drain issue 100C: poison=%0b rv=%0b busy=%0b", o_poison, o_rv, o_busy);
    n_checks++; if (o_poison !== 1'b1 || o_rv !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL drain_wrong poison=%0b rv=%0b busy=%0b want=1/0/1", o_poison, o_rv, o_busy); else n_pass++;
    cyc(0, 0, 0, 0, 0, '0, 1, VW'('h2000), 0);
    $display("drain issue 2000: poison=%0b", o_poison);
    n_checks++; if (o_poison !== 1'b0) $display("FAIL drain_hit_poison got=%0b want=0", o_poison); else n_pass++;
    idle(0);
    n_checks++; if (o_busy !== 1'b0) $display("FAIL drain_exit_busy got=%0b want=0", o_busy); else n_pass++;
  endtask

  task automatic test_flush_redirect();
    cyc(0, 0, 0, 0, 0, '0, 1, VW'('h3000), 0);
    n_checks++; if (o_poison !== 1'b1) $display("FAIL fl_mis_poison got=%0b want=1", o_poison); else n_pass++;
    cyc(0, 1, 0, 0, 0, '0, 0, '0, 1);
    $display("flush in redirect: rv=%0b", o_rv);
    n_checks++; if (o_rv !== 1'b0) $display("FAIL fl_redirect_v got=%0b want=0", o_rv); else n_pass++;
    cyc(0, 0, 0, 0, 0, '0, 1, VW'('h1234), 0);
    $display("issue 1234 after flush: poison=%0b busy=%0b", o_poison, o_busy);
    n_checks++; if (o_poison !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL fl_accept poison=%0b busy=%0b want=0/0", o_poison, o_busy); else n_pass++;
    idle(1);
    n_checks++; if (o_rv !== 1'b0) $display("FAIL fl_no_redirect got=%0b want=0", o_rv); else n_pass++;
  endtask

  task automatic test_stats();
    cyc(1, 0, 0, 0, 0, '0, 0, '0, 0);
    idle(0);
    cyc(0, 0, 1, 1, 0, VW'('h1004), 0, '0, 0);
    cyc(0, 0, 0, 0, 0, '0, 1, VW'('h1004), 0);
    cyc(0, 0, 1, 1, 1, VW'('h2000), 1, VW'('h1008), 0);
    cyc(0, 0, 1, 1, 0, VW'('h3000), 0, '0, 1);
    idle(0);
    $display("stats: branch_cnt=%0d mispredict_cnt=%0d", o_bcnt, o_mcnt);
    n_checks++; if (o_bcnt !== CW'(STATS ? 3 : 0)) $display("FAIL stats_branch got=%0d want=%0d", o_bcnt, STATS ? 3 : 0); else n_pass++;
    n_checks++; if (o_mcnt !== CW'(STATS ? 1 : 0)) $display("FAIL stats_mis got=%0d want=%0d", o_mcnt, STATS ? 1 : 0); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 0, 0, '0, 0, '0, 0);
      cyc(0, 0, 1, 1, 0, VW'('h4000), 1, VW'('h4004), 0);
      idle(0);
    end
    $display("stats after saturation run: branch_cnt=%0d mispredict_cnt=%0d", o_bcnt, o_mcnt);
    n_checks++; if (o_bcnt !== e_bcnt) $display("FAIL stats_sat_branch got=%0d want=%0d", o_bcnt, e_bcnt); else n_pass++;
    n_checks++; if (o_mcnt !== e_mcnt) $display("FAIL stats_sat_mis got=%0d want=%0d", o_mcnt, e_mcnt); else n_pass++;
    cyc(1, 0, 0, 0, 0, '0, 0, '0, 0);
    idle(0);
    idle(0);
    n_checks++; if (o_bcnt !== '0 || o_mcnt !== '0)
      $display("FAIL stats_reset got=%0d/%0d want=0/0", o_bcnt, o_mcnt); else n_pass++;
  endtask

  task automatic test_random();
    logic [VW-1:0] pool_pc;
    logic [VW-1:0] pick;
    bit            r, f, bv, v;
    logic [VW-1:0] bn;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 24) == 0);
      bv = $urandom_range(0, 1);
      v  = ($urandom_range(0, 2) != 0);
      bn = VW'('h1000 + 4 * $urandom_range(0, 7));
      pool_pc = VW'('h1000 + 4 * $urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: pick = bv ? bn : m_npc;
        5, 6:          pick = m_tgt;
        default:       pick = pool_pc;
      endcase
      cyc(r, f, bv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bn, v, pick,
          1'($urandom_range(0, 1)));
      $display("rand %0d: rst=%0b fl=%0b br=%0b npc=%0h iv=%0b pc=%0h -> poison=%0b rv=%0b busy=%0b",
               i, r, f, bv, bn, v, pick, o_poison, o_rv, o_busy);
      n_checks++; if (o_poison !== e_poison) $display("FAIL rand_poison cyc=%0d got=%0b want=%0b", i, o_poison, e_poison); else n_pass++;
      n_checks++; if (o_rv !== e_rv) $display("FAIL rand_redirect_v cyc=%0d got=%0b want=%0b", i, o_rv, e_rv); else n_pass++;
      n_checks++; if (o_rnpc !== e_rnpc) $display("FAIL rand_redirect_npc cyc=%0d got=%0h want=%0h", i, o_rnpc, e_rnpc); else n_pass++;
      n_checks++; if (o_rb !== e_rb || o_rt !== e_rt)
        $display("FAIL rand_attr cyc=%0d got=%0b%0b want=%0b%0b", i, o_rb, o_rt, e_rb, e_rt); else n_pass++;
      n_checks++; if (o_busy !== e_busy) $display("FAIL rand_busy cyc=%0d got=%0b want=%0b", i, o_busy, e_busy); else n_pass++;
      n_checks++; if (o_bcnt !== e_bcnt || o_mcnt !== e_mcnt)
        $display("FAIL rand_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i, o_bcnt, o_mcnt, e_bcnt, e_mcnt); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_no_packet();
    test_correct_predict();
    test_mispredict_redirect();
    test_stall_drain();
    test_flush_redirect();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
